// File: rtl/aq_getfreq_meter.sv
// Frequency meter on the AQ local bus: counts synchronized EXT_CLK rising edges over a
// programmable gate window, single-shot or continuous.
module aq_getfreq_meter #(
    parameter logic [31:0] GATE_DEFAULT = 32'd100_000_000,
    parameter int unsigned SYNC_STAGES  = 3
) (
    input  logic        RST_N,
    input  logic        AQ_LOCAL_CLK,
    input  logic        AQ_LOCAL_CS,
    input  logic        AQ_LOCAL_RNW,
    output logic        AQ_LOCAL_ACK,
    input  logic [15:0] AQ_LOCAL_ADDR,
    input  logic [3:0]  AQ_LOCAL_BE,
    input  logic [31:0] AQ_LOCAL_WDATA,
    output logic [31:0] AQ_LOCAL_RDATA,
    input  logic        EXT_CLK,
    output logic [31:0] DEBUG
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGate  = 2'd1,
        StLatch = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   en_q, en_d;
    logic [31:0]            gate_q, gate_d;
    logic [31:0]            count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic [15:0]            seq_q, seq_d;
    logic [31:0]            gcnt_q, gcnt_d;
    logic [31:0]            ecnt_q, ecnt_d;
    logic                   wovf_q, wovf_d;

    logic        acc, wr, rd, start_wr, ext_edge, busy, hits_max;
    logic [1:0]  reg_sel;
    logic [31:0] gate_eff, ecnt_next;
    logic        unused_addr;

    assign unused_addr = ^{AQ_LOCAL_ADDR[15:4], AQ_LOCAL_ADDR[1:0]};

    always_comb begin
        acc       = AQ_LOCAL_CS & ~ack_q;
        wr        = acc & ~AQ_LOCAL_RNW;
        rd        = acc & AQ_LOCAL_RNW;
        reg_sel   = AQ_LOCAL_ADDR[3:2];
        start_wr  = wr && (reg_sel == 2'd0) && AQ_LOCAL_BE[0] && AQ_LOCAL_WDATA[1];
        ext_edge  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
        busy      = (state_q != StIdle);
        gate_eff  = (gate_q == 32'd0) ? 32'd1 : gate_q;
        ecnt_next = (ecnt_q == 32'hFFFF_FFFF) ? ecnt_q : ecnt_q + 32'd1;
        // The window saturates once the count reaches (or sits at) all-ones.
        hits_max  = ext_edge && (ecnt_q >= 32'hFFFF_FFFE);

        state_d = state_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], EXT_CLK};
        ack_d   = acc;
        rdata_d = 32'd0;
        en_d    = en_q;
        gate_d  = gate_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        seq_d   = seq_q;
        gcnt_d  = gcnt_q;
        ecnt_d  = ecnt_q;
        wovf_d  = wovf_q;

        if (rd) begin
            case (reg_sel)
                2'd0:    rdata_d = {31'd0, en_q};
                2'd1:    rdata_d = gate_q;
                2'd2:    rdata_d = count_q;
                default: rdata_d = {seq_q, 13'd0, ovf_q, busy, valid_q};
            endcase
        end

        if (wr) begin
            case (reg_sel)
                2'd0: if (AQ_LOCAL_BE[0]) en_d = AQ_LOCAL_WDATA[0];
                2'd1: begin
                    for (int b = 0; b < 4; b++) begin
                        if (AQ_LOCAL_BE[b]) gate_d[8*b +: 8] = AQ_LOCAL_WDATA[8*b +: 8];
                    end
                end
                2'd3: begin
                    if (AQ_LOCAL_BE[0] && AQ_LOCAL_WDATA[0]) valid_d = 1'b0;
                    if (AQ_LOCAL_BE[0] && AQ_LOCAL_WDATA[2]) ovf_d = 1'b0;
                end
                default: ;
            endcase
        end

        // FSM updates come after the bus so a LATCH overrides a same-cycle status clear.
        case (state_q)
            StIdle: begin
                if (en_q || start_wr) begin
                    state_d = StGate;
                    gcnt_d  = gate_eff;
                    ecnt_d  = 32'd0;
                    wovf_d  = 1'b0;
                end
            end
            StGate: begin
                gcnt_d = gcnt_q - 32'd1;
                if (ext_edge) ecnt_d = ecnt_next;
                wovf_d = wovf_q | hits_max;
                if (gcnt_q == 32'd1) state_d = StLatch;
            end
            StLatch: begin
                count_d = ext_edge ? ecnt_next : ecnt_q;
                valid_d = 1'b1;
                if (wovf_q || hits_max) ovf_d = 1'b1;
                seq_d = seq_q + 16'd1;
                if (en_q) begin
                    state_d = StGate;
                    gcnt_d  = gate_eff;
                    ecnt_d  = 32'd0;
                    wovf_d  = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge AQ_LOCAL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            sync_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            en_q    <= 1'b0;
            gate_q  <= GATE_DEFAULT;
            count_q <= 32'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            seq_q   <= 16'd0;
            gcnt_q  <= 32'd0;
            ecnt_q  <= 32'd0;
            wovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            gate_q  <= gate_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            seq_q   <= seq_d;
            gcnt_q  <= gcnt_d;
            ecnt_q  <= ecnt_d;
            wovf_q  <= wovf_d;
        end
    end

    assign AQ_LOCAL_ACK   = ack_q;
    assign AQ_LOCAL_RDATA = rdata_q;
    assign DEBUG          = {state_q, busy, valid_q, ovf_q, 11'd0, seq_q};

endmodule

// File: tb/tb_aq_getfreq_meter.sv
// Self-checking bench for aq_getfreq_meter: table of single-shot windows, continuous mode,
// bus rules, overflow and reset corner cases, with a queue of expected COUNT ranges.
module tb_aq_getfreq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        rnw = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        ext_clk = 1'b0;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] debug;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ext_div = 0;
    int ext_cnt = 0;
    logic [15:0] exp_seq = 16'd0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [31:0] gate;
        int          div;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    aq_getfreq_meter #(
        .GATE_DEFAULT (32'd100_000_000),
        .SYNC_STAGES  (3)
    ) dut (
        .RST_N          (rst_n),
        .AQ_LOCAL_CLK   (clk),
        .AQ_LOCAL_CS    (cs),
        .AQ_LOCAL_RNW   (rnw),
        .AQ_LOCAL_ACK   (ack),
        .AQ_LOCAL_ADDR  (addr),
        .AQ_LOCAL_BE    (be),
        .AQ_LOCAL_WDATA (wdata),
        .AQ_LOCAL_RDATA (rdata),
        .EXT_CLK        (ext_clk),
        .DEBUG          (debug)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // EXT_CLK with period ext_div local cycles; 0 holds it low.
    always @(negedge clk) begin
        if (ext_div == 0) begin
            ext_clk = 1'b0;
            ext_cnt = 0;
        end else begin
            ext_clk = (ext_cnt < ext_div / 2);
            ext_cnt = (ext_cnt + 1 >= ext_div) ? 0 : ext_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic bus(input logic is_rd, input logic [15:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rv, output int t);
        int n;
        n = 0;
        cs = 1'b1; rnw = is_rd; addr = a; be = b; wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        if (!ack) begin
            total++; bad++;
            $display("FAIL bus_ack_timeout: got no ack want ack within 20 cycles");
        end
        rv = rdata;
        t = cyc;
        cs = 1'b0; rnw = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", {31'd0, ack}, 32'd0);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d,
                          output int t);
        logic [31:0] dummy;
        bus(1'b0, a, b, d, dummy, t);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] rv);
        int t;
        bus(1'b1, a, 4'hF, 32'd0, rv, t);
    endtask

    task automatic wait_done(input logic [15:0] prev, output int t);
        int n;
        n = 0;
        while (debug[15:0] == prev && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (debug[15:0] == prev) begin
            total++; bad++;
            $display("FAIL wait_done_timeout: got seq %h want change", debug[15:0]);
        end
        t = cyc;
    endtask

    task automatic check_count(input string name);
        logic [31:0] v;
        exp_t e;
        bus_rd(16'h0008, v);
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: got empty scoreboard want entry", name);
        end else begin
            e = sb_q.pop_front();
            check_rng(name, v, e.lo, e.hi);
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] v;
        int          t_w, t_d, t_prev, t_x;
        logic [31:0] eff;

        vecs[0] = '{gate: 32'd1000, div: 10, lo: 32'd100, hi: 32'd101};
        vecs[1] = '{gate: 32'd64,   div: 2,  lo: 32'd32,  hi: 32'd33};
        vecs[2] = '{gate: 32'd0,    div: 2,  lo: 32'd1,   hi: 32'd1};
        vecs[3] = '{gate: 32'd40,   div: 4,  lo: 32'd10,  hi: 32'd11};
        vecs[4] = '{gate: 32'd1,    div: 0,  lo: 32'd0,   hi: 32'd0};
        vecs[5] = '{gate: 32'd200,  div: 0,  lo: 32'd0,   hi: 32'd0};

        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_debug", debug, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(16'h0000, v); check("rst_ctrl", v, 32'd0);
        bus_rd(16'h0004, v); check("rst_gate", v, 32'd100_000_000);
        bus_rd(16'h0008, v); check("rst_count", v, 32'd0);
        bus_rd(16'h000C, v); check("rst_status", v, 32'd0);

        for (int i = 0; i < 6; i++) begin
            ext_div = vecs[i].div;
            repeat (20) @(negedge clk);
            bus_wr(16'h0004, 4'hF, vecs[i].gate, t_x);
            sb_q.push_back('{lo: vecs[i].lo, hi: vecs[i].hi});
            bus_wr(16'h0000, 4'h1, 32'h2, t_w);
            wait_done(exp_seq, t_d);
            exp_seq++;
            eff = (vecs[i].gate == 32'd0) ? 32'd1 : vecs[i].gate;
            check("ss_latency", t_d - t_w, eff + 32'd1);
            check_count("ss_count");
            bus_rd(16'h000C, v);
            check("ss_status", v, {exp_seq, 16'h0001});
        end

        // Last table entry left COUNT at 0; a write must not change it.
        bus_wr(16'h0008, 4'hF, 32'hFFFF_FFFF, t_x);
        bus_rd(16'h0008, v); check("count_ro", v, 32'd0);

        bus_wr(16'h0004, 4'hF, 32'h1234_5678, t_x);
        bus_wr(16'h0004, 4'h1, 32'hAABB_CCDD, t_x);
        bus_rd(16'h0004, v); check("gate_be0", v, 32'h1234_56DD);

        // CS held high: ACK pattern 1,0,1,0.
        cs = 1'b1; rnw = 1'b1; addr = 16'h0000; be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ack_period", {31'd0, ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        cs = 1'b0; rnw = 1'b0;
        repeat (2) @(negedge clk);

        // START while busy is ignored.
        bus_wr(16'h0004, 4'hF, 32'd300, t_x);
        bus_wr(16'h0000, 4'h1, 32'h2, t_w);
        repeat (20) @(negedge clk);
        bus_wr(16'h0000, 4'h1, 32'h2, t_x);
        wait_done(exp_seq, t_d);
        exp_seq++;
        check("busy_start_latency", t_d - t_w, 32'd301);
        repeat (400) @(negedge clk);
        check("busy_start_seq", {16'd0, debug[15:0]}, {16'd0, exp_seq});
        check("busy_start_idle", {31'd0, debug[29]}, 32'd0);

        // VALID clear landing on the LATCH edge.
        bus_wr(16'h000C, 4'h1, 32'h1, t_x);
        bus_wr(16'h0004, 4'hF, 32'd20, t_x);
        bus_wr(16'h0000, 4'h1, 32'h2, t_w);
        while (cyc < t_w + 20) @(negedge clk);
        bus_wr(16'h000C, 4'h1, 32'h1, t_x);
        exp_seq++;
        bus_rd(16'h000C, v); check("valid_clr_vs_latch", v, {exp_seq, 16'h0001});
        bus_wr(16'h000C, 4'h1, 32'h1, t_x);
        bus_rd(16'h000C, v); check("valid_clr", v, {exp_seq, 16'h0000});

        // Continuous mode.
        ext_div = 4;
        repeat (20) @(negedge clk);
        bus_wr(16'h0004, 4'hF, 32'd500, t_x);
        bus_wr(16'h0000, 4'h1, 32'h1, t_x);
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{lo: 32'd125, hi: 32'd126});
            wait_done(exp_seq, t_d);
            exp_seq++;
            check("cont_seq", {16'd0, debug[15:0]}, {16'd0, exp_seq});
            check("cont_busy", {31'd0, debug[29]}, 32'd1);
            if (i > 0) check("cont_period", t_d - t_prev, 32'd501);
            t_prev = t_d;
            check_count("cont_count");
        end
        bus_wr(16'h0000, 4'h1, 32'h0, t_x);
        wait_done(exp_seq, t_d);
        exp_seq++;
        check("cont_stop_idle", {31'd0, debug[29]}, 32'd0);

        // Overflow: preload the edge counter near saturation mid-window.
        ext_div = 2;
        repeat (20) @(negedge clk);
        bus_wr(16'h0004, 4'hF, 32'd64, t_x);
        sb_q.push_back('{lo: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFF});
        bus_wr(16'h0000, 4'h1, 32'h2, t_w);
        repeat (5) @(negedge clk);
        force dut.ecnt_q = 32'hFFFF_FFF0;
        #1;
        release dut.ecnt_q;
        wait_done(exp_seq, t_d);
        exp_seq++;
        check_count("ovf_count");
        bus_rd(16'h000C, v); check("ovf_status", v, {exp_seq, 16'h0005});
        sb_q.push_back('{lo: 32'd32, hi: 32'd33});
        bus_wr(16'h0000, 4'h1, 32'h2, t_w);
        wait_done(exp_seq, t_d);
        exp_seq++;
        check_count("ovf_next_count");
        bus_rd(16'h000C, v); check("ovf_sticky", v, {exp_seq, 16'h0005});
        bus_wr(16'h000C, 4'h1, 32'h4, t_x);
        bus_rd(16'h000C, v); check("ovf_clear", v, {exp_seq, 16'h0001});
        check("sb_empty", sb_q.size(), 32'd0);

        // Asynchronous reset mid-window.
        bus_wr(16'h0004, 4'hF, 32'd1000, t_x);
        bus_wr(16'h0000, 4'h1, 32'h2, t_w);
        repeat (50) @(negedge clk);
        check("pre_rst_busy", {31'd0, debug[29]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", {31'd0, ack}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_debug", debug, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1100) @(negedge clk);
        check("post_rst_debug", debug, 32'd0);
        bus_rd(16'h0000, v); check("post_rst_ctrl", v, 32'd0);
        bus_rd(16'h0004, v); check("post_rst_gate", v, 32'd100_000_000);
        bus_rd(16'h0008, v); check("post_rst_count", v, 32'd0);
        bus_rd(16'h000C, v); check("post_rst_status", v, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
